// File: rtl/mux2_arb_pkg.sv
// Shared constants for the two-requester round-robin mux arbiter:
// FSM state codes and the output source tags.
package mux2_arb_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  localparam logic SRC_IN0 = 1'b0;
  localparam logic SRC_IN1 = 1'b1;

endpackage

// File: rtl/mux2_bus.sv
// Behavioural 2:1 bus multiplexer; sel = 0 routes a0, sel = 1 routes a1.
module mux2_bus #(
  parameter int W = 9
) (
  input  logic         sel,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] a1,
  output logic [W-1:0] y
);

  assign y = sel ? a1 : a0;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin, packet-aware arbiter sharing one 2:1 mux between two valid/ready
// requesters, with a burst cap and a one-entry registered output stage.
module mux2_rr_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_last,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_src,
  input  logic             out_ready,
  output logic [1:0]       grant
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CAP = CW'(MAX_BURST);

  logic [1:0]       state, state_nxt;
  logic             ptr, ptr_nxt;
  logic [CW-1:0]    cnt, cnt_nxt, cnt_inc;
  logic [WIDTH-1:0] sel_data;
  logic             sel_last;
  logic             sel_valid, other_valid;
  logic             out_free, accept, release_gnt;

  assign grant     = {state == GNT1, state == GNT0};
  assign out_free  = ~out_valid | out_ready;
  assign in0_ready = grant[0] & out_free;
  assign in1_ready = grant[1] & out_free;

  mux2_bus #(.W(WIDTH + 1)) u_bus (
    .sel (grant[1]),
    .a0  ({in0_last, in0_data}),
    .a1  ({in1_last, in1_data}),
    .y   ({sel_last, sel_data})
  );

  assign sel_valid   = grant[1] ? in1_valid : in0_valid;
  assign other_valid = grant[1] ? in0_valid : in1_valid;
  assign accept      = sel_valid & (in0_ready | in1_ready);

  // cnt_inc is the ordinal of the beat being accepted, saturating at the cap
  assign cnt_inc     = (cnt == CAP) ? cnt : cnt + CW'(1);
  assign release_gnt = accept & (sel_last | ((cnt_inc == CAP) & other_valid));

  // The released side's valid was just consumed by the accepted beat, so with
  // the other side idle the arbiter drops back to IDLE and re-arbitrates.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (in0_valid & in1_valid) state_nxt = ptr ? GNT1 : GNT0;
        else if (in0_valid)        state_nxt = GNT0;
        else if (in1_valid)        state_nxt = GNT1;
      end
      GNT0, GNT1: begin
        if (release_gnt) begin
          ptr_nxt   = ~grant[1];
          cnt_nxt   = '0;
          state_nxt = other_valid ? (grant[1] ? GNT0 : GNT1) : IDLE;
        end else if (accept) begin
          cnt_nxt = cnt_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= SRC_IN0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Output stage: reload on accept, otherwise empty once the consumer takes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= SRC_IN0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_last  <= sel_last;
      out_src   <= grant[1] ? SRC_IN1 : SRC_IN0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter: cycle tables for the basic flows plus
// a queue-driven engine with a per-source scoreboard for bursts, stalls and random traffic.
module tb_mux2_rr_arbiter;

  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in0_valid, in0_last, in0_ready;
  logic [WIDTH-1:0] in0_data;
  logic             in1_valid, in1_last, in1_ready;
  logic [WIDTH-1:0] in1_data;
  logic             out_valid, out_last, out_src, out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       grant;

  int compared   = 0;
  int mismatched = 0;

  mux2_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_src(out_src),
    .out_ready(out_ready), .grant(grant)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v0;
    logic [7:0] d0;
    logic       l0;
    logic       v1;
    logic [7:0] d1;
    logic       l1;
    logic       ordy;
    logic [1:0] egrant;
    logic       er0;
    logic       er1;
    logic       eov;
    logic [7:0] edata;
    logic       elast;
    logic       esrc;
  } vec_t;

  vec_t tbl[$];

  // Reference model: per-source ordered beat lists ({last,data}) plus observed stream
  logic [8:0] q0[$], q1[$], exp0[$], exp1[$];
  int obs_src[$], obs_last[$], obs_cyc[$];

  int e4_src[7]  = '{0, 0, 0, 0, 1, 0, 0};
  int e4_last[7] = '{0, 0, 0, 0, 1, 0, 1};

  function automatic vec_t mk(input logic v0, input logic [7:0] d0, input logic l0,
                              input logic v1, input logic [7:0] d1, input logic l1,
                              input logic ordy, input logic [1:0] eg, input logic er0,
                              input logic er1, input logic eov, input logic [7:0] ed,
                              input logic el, input logic es);
    vec_t v;
    v.v0 = v0; v.d0 = d0; v.l0 = l0; v.v1 = v1; v.d1 = d1; v.l1 = l1; v.ordy = ordy;
    v.egrant = eg; v.er0 = er0; v.er1 = er1; v.eov = eov; v.edata = ed; v.elast = el;
    v.esrc = es;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic resetDut();
    rst = 1'b1;
    in0_valid = 1'b0; in0_data = '0; in0_last = 1'b0;
    in1_valid = 1'b0; in1_data = '0; in1_last = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic runTable(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      in0_valid = tbl[i].v0; in0_data = tbl[i].d0; in0_last = tbl[i].l0;
      in1_valid = tbl[i].v1; in1_data = tbl[i].d1; in1_last = tbl[i].l1;
      out_ready = tbl[i].ordy;
      #1;
      checkOutput($sformatf("v%0d_grant", i), grant, tbl[i].egrant);
      checkOutput($sformatf("v%0d_rdy", i), {in1_ready, in0_ready}, {tbl[i].er1, tbl[i].er0});
      checkOutput($sformatf("v%0d_ovalid", i), out_valid, tbl[i].eov);
      if (tbl[i].eov)
        checkOutput($sformatf("v%0d_beat", i), {out_src, out_last, out_data},
                    {tbl[i].esrc, tbl[i].elast, tbl[i].edata});
    end
  endtask

  task automatic loadPacket(input int src, input int len, input logic [7:0] base);
    for (int k = 0; k < len; k++) begin
      if (src == 0) begin
        q0.push_back({k == len - 1, base + 8'(k)});
        exp0.push_back({k == len - 1, base + 8'(k)});
      end else begin
        q1.push_back({k == len - 1, base + 8'(k)});
        exp1.push_back({k == len - 1, base + 8'(k)});
      end
    end
  endtask

  task automatic applyStimulus(input int ncyc, input int vpct, input int rpct,
                               input int stall_from, input int stall_len);
    logic       pov, por;
    logic [9:0] pout;
    int         c;
    pov = 1'b0; por = 1'b0; pout = '0; c = 0;
    obs_src.delete(); obs_last.delete(); obs_cyc.delete();
    while (c < ncyc && (exp0.size() > 0 || exp1.size() > 0)) begin
      @(negedge clk);
      in0_valid = (q0.size() > 0) && ($urandom_range(99) < vpct);
      {in0_last, in0_data} = in0_valid ? q0[0] : 9'h0;
      in1_valid = (q1.size() > 0) && ($urandom_range(99) < vpct);
      {in1_last, in1_data} = in1_valid ? q1[0] : 9'h0;
      out_ready = ($urandom_range(99) < rpct) && !(c >= stall_from && c < stall_from + stall_len);
      #1;
      if (pov && !por) begin
        checkOutput("hold_valid", out_valid, 1);
        checkOutput("hold_beat", {out_src, out_last, out_data}, pout);
      end
      if (out_valid && !out_ready)
        checkOutput("stall_rdy", {in1_ready, in0_ready}, 0);
      if (out_valid && out_ready) begin
        compared++;
        if ((out_src == 1'b0 && exp0.size() == 0) || (out_src == 1'b1 && exp1.size() == 0)) begin
          mismatched++;
          $display("[TB] FAIL extra_beat: got src %0d data 0x%0h, expected no beat", out_src, out_data);
        end else if ({out_last, out_data} !== (out_src ? exp1[0] : exp0[0])) begin
          mismatched++;
          $display("[TB] FAIL sb_beat: got 0x%0h from src %0d, expected 0x%0h", {out_last, out_data},
                   out_src, out_src ? exp1[0] : exp0[0]);
        end
        if (out_src == 1'b0 && exp0.size() > 0) void'(exp0.pop_front());
        if (out_src == 1'b1 && exp1.size() > 0) void'(exp1.pop_front());
        obs_src.push_back(int'(out_src));
        obs_last.push_back(int'(out_last));
        obs_cyc.push_back(c);
      end
      if (in0_valid && in0_ready) void'(q0.pop_front());
      if (in1_valid && in1_ready) void'(q1.pop_front());
      pov = out_valid; por = out_ready; pout = {out_src, out_last, out_data};
      c++;
    end
    checkOutput("drain_in0", exp0.size(), 0);
    checkOutput("drain_in1", exp1.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // in0-only 3-beat packet
    tbl.push_back(mk(1, 8'h11, 0, 0, 8'h00, 0, 1, 2'b00, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 8'h11, 0, 0, 8'h00, 0, 1, 2'b01, 1, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 8'h22, 0, 0, 8'h00, 0, 1, 2'b01, 1, 0, 1, 8'h11, 0, 0));
    tbl.push_back(mk(1, 8'h33, 1, 0, 8'h00, 0, 1, 2'b01, 1, 0, 1, 8'h22, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 1, 2'b00, 0, 0, 1, 8'h33, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 1, 2'b00, 0, 0, 0, 8'h00, 0, 0));
    // both sides continuously valid, 2-beat packets
    tbl.push_back(mk(1, 8'hA0, 0, 1, 8'hB0, 0, 1, 2'b00, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 8'hA0, 0, 1, 8'hB0, 0, 1, 2'b01, 1, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 8'hA1, 1, 1, 8'hB0, 0, 1, 2'b01, 1, 0, 1, 8'hA0, 0, 0));
    tbl.push_back(mk(1, 8'hA2, 0, 1, 8'hB0, 0, 1, 2'b10, 0, 1, 1, 8'hA1, 1, 0));
    tbl.push_back(mk(1, 8'hA2, 0, 1, 8'hB1, 1, 1, 2'b10, 0, 1, 1, 8'hB0, 0, 1));
    tbl.push_back(mk(1, 8'hA2, 0, 1, 8'hB2, 0, 1, 2'b01, 1, 0, 1, 8'hB1, 1, 1));
    tbl.push_back(mk(1, 8'hA3, 1, 1, 8'hB2, 0, 1, 2'b01, 1, 0, 1, 8'hA2, 0, 0));
    tbl.push_back(mk(1, 8'hA4, 0, 1, 8'hB2, 0, 1, 2'b10, 0, 1, 1, 8'hA3, 1, 0));
    tbl.push_back(mk(1, 8'hA4, 0, 1, 8'hB3, 1, 1, 2'b10, 0, 1, 1, 8'hB2, 0, 1));
    tbl.push_back(mk(1, 8'hA4, 0, 1, 8'hB4, 0, 1, 2'b01, 1, 0, 1, 8'hB3, 1, 1));

    rst = 1'b1;
    in0_valid = 1'b0; in0_data = '0; in0_last = 1'b0;
    in1_valid = 1'b0; in1_data = '0; in1_last = 1'b0;
    out_ready = 1'b0;
    #1;
    checkOutput("reset_out", {out_valid, out_src, out_last, out_data}, 0);
    checkOutput("reset_grant", grant, 0);
    resetDut();

    $display("[TB] single requester packet");
    runTable(0, 5);
    resetDut();
    $display("[TB] alternating packets");
    runTable(6, 15);

    $display("[TB] asynchronous reset mid-packet");
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_out", {out_valid, out_src, out_last, out_data}, 0);
    checkOutput("midrst_grant", grant, 0);
    checkOutput("midrst_rdy", {in1_ready, in0_ready}, 0);
    resetDut();

    $display("[TB] burst cap switch");
    loadPacket(0, 6, 8'h40);
    loadPacket(1, 1, 8'h80);
    applyStimulus(60, 100, 100, -1, 0);
    checkOutput("t4_count", obs_src.size(), 7);
    for (int k = 0; k < 7 && k < obs_src.size(); k++) begin
      checkOutput($sformatf("t4_src%0d", k), obs_src[k], e4_src[k]);
      checkOutput($sformatf("t4_last%0d", k), obs_last[k], e4_last[k]);
    end
    resetDut();

    $display("[TB] backpressure");
    loadPacket(0, 4, 8'h50);
    loadPacket(1, 2, 8'h90);
    applyStimulus(60, 100, 100, 3, 3);
    checkOutput("t5_count", obs_src.size(), 6);
    resetDut();

    $display("[TB] long single-requester packet");
    loadPacket(0, 8, 8'h60);
    applyStimulus(60, 100, 100, -1, 0);
    checkOutput("t6_count", obs_src.size(), 8);
    for (int k = 1; k < obs_cyc.size(); k++)
      checkOutput($sformatf("t6_b2b%0d", k), obs_cyc[k] - obs_cyc[k-1], 1);
    resetDut();

    $display("[TB] random traffic");
    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p < 3; p++) begin
        loadPacket(0, int'($urandom_range(7, 1)), 8'($urandom));
        loadPacket(1, int'($urandom_range(7, 1)), 8'($urandom));
      end
      applyStimulus(800, 70, 70, -1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
